// File: rtl/rep3_serial_tx.sv
// rep3_serial_tx
// Triple-repetition serial transmitter. Each accepted word is sent LSB first.
// Every bit is sent as three consecutive samples, so the receiver can recover
// it with a 3-input majority vote. A one-word holding buffer lets a second
// word be queued while a frame is in flight, so frames can run back-to-back.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_data/in_valid/    parallel word input with valid/ready handshake
//   in_ready
//   tx_bit/tx_valid/     serial sample output; a sample moves on tx_valid & tx_ready
//   tx_ready
//   tx_first, tx_last    frame delimiters (bit 0 rep 0, bit DATA_W-1 rep 2)
//   busy                 frame in progress or word held
//   frame_cnt            completed frames, wraps
//
// state | meaning
// IDLE  | nothing to send, tx_valid low
// SEND  | emitting shifter[0], tracking repetition and bit position
module rep3_serial_tx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_first,
  output logic              tx_last,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shifter;
  logic [DATA_W-1:0] hold;
  logic              hold_valid;
  logic [1:0]        rep_cnt;
  logic [BW-1:0]     bit_cnt;

  logic accept;
  logic xfer;
  logic frame_end;

  assign in_ready  = ~hold_valid & rst_n;
  assign accept    = in_valid & in_ready;
  assign xfer      = (state == SEND) & tx_ready;
  assign frame_end = xfer & tx_last;

  assign tx_valid = (state == SEND);
  // Gated so the line idles low instead of showing leftover shifter bits.
  assign tx_bit   = (state == SEND) & shifter[0];
  assign tx_first = (state == SEND) & (bit_cnt == '0) & (rep_cnt == 2'd0);
  assign tx_last  = (state == SEND) & (bit_cnt == LAST_BIT) & (rep_cnt == 2'd2);
  assign busy     = (state == SEND) | hold_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (frame_end && !hold_valid && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shifter    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      rep_cnt    <= 2'd0;
      bit_cnt    <= '0;
      frame_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (xfer) begin
        if (rep_cnt != 2'd2) begin
          rep_cnt <= rep_cnt + 2'd1;
        end else begin
          rep_cnt <= 2'd0;
          if (bit_cnt != LAST_BIT) begin
            bit_cnt <= bit_cnt + BW'(1);
            shifter <= shifter >> 1;
          end else begin
            bit_cnt   <= '0;
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
      end

      // The held word always goes first at a frame end; in_ready is low while
      // it is held, so a simultaneous accept cannot collide with it.
      if (frame_end) begin
        if (hold_valid) begin
          shifter    <= hold;
          hold_valid <= 1'b0;
        end else if (accept) begin
          shifter <= in_data;
        end
      end else if (accept) begin
        if (state == IDLE) begin
          shifter <= in_data;
        end else begin
          hold       <= in_data;
          hold_valid <= 1'b1;
        end
      end
    end
  end

endmodule
